axi_lite_sram: RTL and testbench
================================

AXI_LITE_SRAM -- requirements
Module: axi_lite_sram

Interface
REQ-001 SHALL have parameter BASE, default 32'h8000_0000, byte address of word 0.
REQ-002 SHALL have parameter ADDR_BITS, default 10, word-index width (depth = 2^ADDR_BITS words of 32 bits).
REQ-003 SHALL have parameter READ_LAT, default 1, cycles from AR handshake to rvalid (legal 1..15).
REQ-004 SHALL have parameter WRITE_LAT, default 1, cycles from the later of AW/W capture to bvalid (legal 1..15).
REQ-005 Ports: clk in 1 clock; rst in 1 reset; one clock; reset is asynchronous and active-high.
REQ-006 Read: araddr in 32; arvalid in 1; arready out 1; rdata out 32; rresp out 2; rvalid out 1; rready in 1.
REQ-007 Write: awaddr in 32; awvalid in 1; awready out 1; wdata in 32; wstrb in 4; wvalid in 1; wready out 1; bresp out 2; bvalid out 1; bready in 1.

Function
REQ-008 SHALL act as an AXI4-lite responder; a handshake completes on a rising clk when valid and ready are both 1.
REQ-009 Read FSM SHALL use states R_IDLE (arready=1), R_WAIT (counter runs), R_RESP (rvalid=1); one read outstanding at most.
REQ-010 R_IDLE->R_WAIT on AR handshake, capturing araddr; R_WAIT->R_RESP when counter reaches READ_LAT-1; R_RESP->R_IDLE on R handshake.
REQ-011 rdata/rresp SHALL be registered on entry to R_RESP and held stable while rvalid=1 and rready=0.
REQ-012 Write FSM SHALL use states W_IDLE, W_WAIT, W_RESP; in W_IDLE awready=1 until AW captured and wready=1 until W captured, independently, in either order or the same cycle.
REQ-013 W_IDLE->W_WAIT once both AW and W are captured; W_WAIT->W_RESP after WRITE_LAT-1 further cycles, committing the write on that transition; W_RESP->W_IDLE on B handshake.
REQ-014 Word index SHALL be addr[ADDR_BITS+1:2]; addr[1:0] ignored; byte lane i written only when wstrb[i]=1.
REQ-015 Address in range iff addr[31:ADDR_BITS+2] equals BASE[31:ADDR_BITS+2]; out of range: rresp/bresp=2'b10 (SLVERR), rdata=0, write dropped; in range: 2'b00.
REQ-016 Read and write channels SHALL be independent; if a read enters R_RESP in the same cycle a write to the same word commits, rdata returns the pre-write value.
REQ-017 wstrb=4'b0000 in range SHALL return OKAY and leave memory unchanged.

Reset
REQ-018 While rst=1: both FSMs idle, counters 0, arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0.
REQ-019 Reset mid-transaction SHALL abandon it with no memory update; memory contents are not reset.

Configuration
REQ-020 Macro AXI_SRAM_RAND_DELAY_EN defined: an 8-bit LFSR (seed 8'hA5 on reset, taps x^8+x^6+x^5+x^4+1, advancing every cycle) adds its low 3 bits (0..7) to the latency sampled at each AR and AW/W-complete event.
REQ-021 Macro undefined: latencies are exactly READ_LAT/WRITE_LAT and no LFSR logic exists.

Structure
REQ-022 Shared package SHALL hold state encodings (R_*/W_*), RESP_OKAY=2'b00, RESP_SLVERR=2'b10, LFSR seed/taps.
REQ-023 One sub-module axi_lite_sram_lfsr SHALL implement the delay LFSR, instantiated only under AXI_SRAM_RAND_DELAY_EN.

Verification
REQ-024 Write 0x8000_0010 data 0xDEADBEEF wstrb 4'hF, then read it -> bresp 00, rdata 0xDEADBEEF, rresp 00, rvalid 1 cycle after AR handshake (READ_LAT=1, macro off).
REQ-025 Word = 0x11223344, write wdata 0xAABBCCDD wstrb 4'b0101 -> read returns 0x11BB33DD.
REQ-026 W presented 3 cycles before AW -> wready drops after W capture, bvalid asserts WRITE_LAT cycles after AW capture, single commit.
REQ-027 Read 0x0000_0000 -> rresp 2'b10, rdata 0; write 0x9000_0000 -> bresp 2'b10, memory unchanged.
REQ-028 Hold rready=0 for 5 cycles in R_RESP -> rvalid, rdata, rresp stable; arready=0 throughout.
REQ-029 Assert rst during W_WAIT -> bvalid=0 next cycle, awready=wready=1, target word retains old value.

Source files
------------

// File: rtl/axi_lite_sram_pkg.sv
// Shared types and constants for the AXI4-lite SRAM responder.
package axi_lite_sram_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // x^8 + x^6 + x^5 + x^4 + 1 as feedback taps on q[7], q[5], q[4], q[3]
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } wbeat_t;

endpackage

// File: rtl/axi_lite_sram_if.sv
// AXI4-lite signal bundle; the SRAM is the slave, the requester the master.
interface axi_lite_sram_if;
  import axi_lite_sram_pkg::*;

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_sram_lfsr.sv
// 8-bit Fibonacci LFSR giving 0..7 extra cycles of latency.
// Only instantiated when AXI_SRAM_RAND_DELAY_EN is defined.
module axi_lite_sram_lfsr
  import axi_lite_sram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] rnd
);

  logic [7:0] q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= LFSR_SEED;
    else     q <= {q[6:0], ^(q & LFSR_TAPS)};
  end

  assign rnd = q[2:0];

endmodule

// File: rtl/axi_lite_sram.sv
// AXI4-lite SRAM responder with independent read and write FSMs.
// Define AXI_SRAM_RAND_DELAY_EN to add 0..7 pseudo-random cycles to each latency.
module axi_lite_sram
  import axi_lite_sram_pkg::*;
#(
  parameter logic [31:0] BASE      = 32'h8000_0000,
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned WRITE_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  axi_lite_sram_if.slave  s
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned HI    = ADDR_BITS + 2;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >> HI) == (BASE >> HI);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  r_state_e              r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_BITS-1:0]  r_idx;
  logic                  r_ok;

  w_state_e              w_state;
  logic [CNT_W-1:0]      w_cnt;
  logic [ADDR_W-1:0]     w_addr;
  wbeat_t                w_beat;

  logic                  aw_hs_c;
  logic                  w_hs_c;
  logic                  w_commit_c;
  logic [ADDR_BITS-1:0]  w_idx_c;

`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [2:0]       rnd;
  logic [CNT_W-1:0] rd_last;
  logic [CNT_W-1:0] wr_last;

  axi_lite_sram_lfsr u_lfsr (
    .clk (clk),
    .rst (rst),
    .rnd (rnd)
  );
`else
  localparam logic [CNT_W-1:0] rd_last = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] wr_last = CNT_W'(WRITE_LAT - 1);
`endif

  assign aw_hs_c    = s.awvalid && s.awready;
  assign w_hs_c     = s.wvalid && s.wready;
  assign w_idx_c    = w_addr[ADDR_BITS+1:2];
  assign w_commit_c = (w_state == W_WAIT) && (w_cnt == wr_last) && in_range(w_addr);

  // Read channel: capture address, count latency, hold response until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= R_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_ok      <= 1'b0;
      s.arready <= 1'b1;
      s.rvalid  <= 1'b0;
      s.rdata   <= '0;
      s.rresp   <= RESP_OKAY;
`ifdef AXI_SRAM_RAND_DELAY_EN
      rd_last   <= '0;
`endif
    end else begin
      case (r_state)
        R_IDLE: if (s.arvalid && s.arready) begin
          r_state   <= R_WAIT;
          r_cnt     <= '0;
          r_idx     <= s.araddr[ADDR_BITS+1:2];
          r_ok      <= in_range(s.araddr);
          s.arready <= 1'b0;
`ifdef AXI_SRAM_RAND_DELAY_EN
          rd_last   <= CNT_W'(READ_LAT - 1) + CNT_W'(rnd);
`endif
        end
        R_WAIT: if (r_cnt == rd_last) begin
          // Same-edge write commit is not yet visible here, so old data returns
          r_state  <= R_RESP;
          s.rvalid <= 1'b1;
          s.rdata  <= r_ok ? mem[r_idx] : '0;
          s.rresp  <= r_ok ? RESP_OKAY : RESP_SLVERR;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        R_RESP: if (s.rready) begin
          r_state   <= R_IDLE;
          s.rvalid  <= 1'b0;
          s.arready <= 1'b1;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write channel: AW and W accepted independently, then latency, then B
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state   <= W_IDLE;
      w_cnt     <= '0;
      w_addr    <= '0;
      w_beat    <= '0;
      s.awready <= 1'b1;
      s.wready  <= 1'b1;
      s.bvalid  <= 1'b0;
      s.bresp   <= RESP_OKAY;
`ifdef AXI_SRAM_RAND_DELAY_EN
      wr_last   <= '0;
`endif
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs_c) begin
            s.awready <= 1'b0;
            w_addr    <= s.awaddr;
          end
          if (w_hs_c) begin
            s.wready <= 1'b0;
            w_beat   <= '{data: s.wdata, strb: s.wstrb};
          end
          if ((aw_hs_c || !s.awready) && (w_hs_c || !s.wready)) begin
            w_state <= W_WAIT;
            w_cnt   <= '0;
`ifdef AXI_SRAM_RAND_DELAY_EN
            wr_last <= CNT_W'(WRITE_LAT - 1) + CNT_W'(rnd);
`endif
          end
        end
        W_WAIT: if (w_cnt == wr_last) begin
          w_state  <= W_RESP;
          s.bvalid <= 1'b1;
          s.bresp  <= in_range(w_addr) ? RESP_OKAY : RESP_SLVERR;
        end else begin
          w_cnt <= w_cnt + CNT_W'(1);
        end
        W_RESP: if (s.bready) begin
          w_state   <= W_IDLE;
          s.bvalid  <= 1'b0;
          s.awready <= 1'b1;
          s.wready  <= 1'b1;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Storage is never reset; commit happens on the W_WAIT -> W_RESP edge
  always_ff @(posedge clk) begin
    if (w_commit_c) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_beat.strb[i]) mem[w_idx_c][8*i +: 8] <= w_beat.data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_sram.sv
// Self-checking bench for axi_lite_sram (default build, READ_LAT = WRITE_LAT = 1).
module tb_axi_lite_sram;

  localparam logic [31:0] BASE      = 32'h8000_0000;
  localparam int unsigned DEPTH     = 1024;
  localparam int          READ_LAT  = 1;
  localparam int          WRITE_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_sram_if bus ();

  axi_lite_sram #(
    .BASE      (BASE),
    .ADDR_BITS (10),
    .READ_LAT  (READ_LAT),
    .WRITE_LAT (WRITE_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model [int unsigned];

  function automatic bit in_rng(input logic [31:0] a);
    longint unsigned x, b;
    x = {32'h0, a};
    b = {32'h0, BASE};
    return (x >= b) && (x < b + 4 * DEPTH);
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    return (a - BASE) / 4;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] st);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (st[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    return in_rng(a) ? model[widx(a)] : 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    if (in_rng(a)) model[widx(a)] = merge(model[widx(a)], d, st);
  endtask

  task automatic timeout(input string what);
    n_tests++; n_fail++;
    $display("FAIL timeout %s: no handshake within bound", what);
  endtask

  // Simultaneous AW and W, then wait for B
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                          output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs;
    int t;
    aw_done = 0; w_done = 0; t = 0;
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata = d; bus.wstrb = st; bus.wvalid = 1'b1;
    while (!(aw_done && w_done) && t < 30) begin
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      @(posedge clk); #1; t++;
      if (aw_hs) begin aw_done = 1; bus.awvalid = 1'b0; end
      if (w_hs)  begin w_done = 1;  bus.wvalid  = 1'b0; end
    end
    if (!(aw_done && w_done)) timeout("aw/w");
    t = 0;
    while (!bus.bvalid && t < 40) begin @(posedge clk); #1; t++; end
    if (!bus.bvalid) timeout("b");
    resp = bus.bresp;
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
  endtask

  // AR, then count cycles to rvalid, optionally stall rready
  task automatic do_read(input logic [31:0] a, input int stall,
                         output logic [31:0] d, output logic [1:0] resp, output int lat);
    int t;
    t = 0;
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b0;
    while (!bus.arready && t < 30) begin @(posedge clk); #1; t++; end
    if (!bus.arready) timeout("ar");
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    lat = 0;
    while (!bus.rvalid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!bus.rvalid) timeout("r");
    repeat (stall) begin @(posedge clk); #1; end
    d = bus.rdata; resp = bus.rresp;
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid} !== 5'b11100) begin
      n_fail++;
      $display("FAIL reset_flags got=%b want=11100",
               {bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid});
    end
    n_tests++;
    if ({bus.rdata, bus.rresp, bus.bresp} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_data rdata=%h rresp=%b bresp=%b want 0", bus.rdata, bus.rresp, bus.bresp);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d; logic [1:0] r; int lat;
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, r);
    model_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    n_tests++; if (r !== 2'b00) begin n_fail++; $display("FAIL basic_bresp got=%b want=00", r); end
    do_read(32'h8000_0010, 0, d, r, lat);
    n_tests++; if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL basic_rdata got=%h want=deadbeef", d); end
    n_tests++; if (r !== 2'b00) begin n_fail++; $display("FAIL basic_rresp got=%b want=00", r); end
    n_tests++; if (lat !== READ_LAT) begin n_fail++; $display("FAIL basic_lat got=%0d want=%0d", lat, READ_LAT); end
  endtask

  task automatic test_strobe();
    logic [31:0] a, d; logic [1:0] r; int lat;
    a = BASE + 32'h40;
    do_write(a, 32'h1122_3344, 4'hF, r);  model_write(a, 32'h1122_3344, 4'hF);
    do_write(a, 32'hAABB_CCDD, 4'b0101, r); model_write(a, 32'hAABB_CCDD, 4'b0101);
    do_read(a + 32'd3, 0, d, r, lat);
    n_tests++; if (d !== 32'h11BB_33DD) begin n_fail++; $display("FAIL strobe_rdata got=%h want=11bb33dd", d); end
    do_write(a, 32'hFFFF_FFFF, 4'b0000, r);
    n_tests++; if (r !== 2'b00) begin n_fail++; $display("FAIL strb0_bresp got=%b want=00", r); end
    do_read(a, 0, d, r, lat);
    n_tests++; if (d !== exp_rdata(a)) begin n_fail++; $display("FAIL strb0_rdata got=%h want=%h", d, exp_rdata(a)); end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] a, wd, d; logic [1:0] r; int lat, t;
    a = BASE + 32'h20; wd = $urandom;
    bus.wdata = wd; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    bus.wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({bus.wready, bus.awready, bus.bvalid} !== 3'b010) begin
        n_fail++; $display("FAIL w_first_ready cyc=%0d got=%b want=010", i, {bus.wready, bus.awready, bus.bvalid});
      end
      @(posedge clk); #1;
    end
    bus.awaddr = a; bus.awvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    t = 0;
    while (!bus.bvalid && t < 40) begin @(posedge clk); #1; t++; end
    n_tests++; if (t !== WRITE_LAT) begin n_fail++; $display("FAIL w_first_blat got=%0d want=%0d", t, WRITE_LAT); end
    n_tests++; if (bus.bresp !== 2'b00) begin n_fail++; $display("FAIL w_first_bresp got=%b want=00", bus.bresp); end
    bus.bready = 1'b1; @(posedge clk); #1; bus.bready = 1'b0;
    model_write(a, wd, 4'hF);
    do_read(a, 0, d, r, lat);
    n_tests++; if (d !== wd) begin n_fail++; $display("FAIL w_first_rdata got=%h want=%h", d, wd); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d, old; logic [1:0] r; int lat;
    old = $urandom;
    do_write(BASE, old, 4'hF, r); model_write(BASE, old, 4'hF);
    do_read(32'h0000_0000, 0, d, r, lat);
    n_tests++; if ({r, d} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL oor_read got resp=%b data=%h want 10/0", r, d); end
    do_write(32'h9000_0000, ~old, 4'hF, r);
    n_tests++; if (r !== 2'b10) begin n_fail++; $display("FAIL oor_bresp got=%b want=10", r); end
    do_read(BASE, 0, d, r, lat);
    n_tests++; if (d !== old) begin n_fail++; $display("FAIL oor_unchanged got=%h want=%h", d, old); end
    do_read(BASE + 4 * DEPTH, 0, d, r, lat);
    n_tests++; if (r !== 2'b10) begin n_fail++; $display("FAIL oor_edge_rresp got=%b want=10", r); end
  endtask

  task automatic test_rready_stall();
    logic [31:0] a; int t;
    a = BASE + 32'h10;
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b0;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    t = 0;
    while (!bus.rvalid && t < 40) begin @(posedge clk); #1; t++; end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({bus.rvalid, bus.arready, bus.rresp, bus.rdata} !== {1'b1, 1'b0, 2'b00, exp_rdata(a)}) begin
        n_fail++;
        $display("FAIL stall cyc=%0d got v=%b ar=%b resp=%b data=%h want 1/0/00/%h",
                 i, bus.rvalid, bus.arready, bus.rresp, bus.rdata, exp_rdata(a));
      end
      @(posedge clk); #1;
    end
    bus.rready = 1'b1; @(posedge clk); #1; bus.rready = 1'b0;
    n_tests++; if ({bus.rvalid, bus.arready} !== 2'b01) begin n_fail++; $display("FAIL stall_release got=%b want=01", {bus.rvalid, bus.arready}); end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] a, old, d; logic [1:0] r; int lat;
    a = BASE + 32'h14; old = $urandom;
    do_write(a, old, 4'hF, r); model_write(a, old, 4'hF);
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata = ~old; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin
      n_fail++; $display("FAIL rst_mid got bv/aw/w=%b want=011", {bus.bvalid, bus.awready, bus.wready});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    do_read(a, 0, d, r, lat);
    n_tests++; if (d !== old) begin n_fail++; $display("FAIL rst_mid_mem got=%h want=%h", d, old); end
  endtask

  // Read reaches R_RESP on the same edge the write to that word commits
  task automatic test_back_to_back();
    logic [31:0] a, old, nw, d; logic [1:0] r; int lat;
    a = BASE + 32'h0C; old = $urandom; nw = ~old;
    do_write(a, old, 4'hF, r); model_write(a, old, 4'hF);
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b0;
    bus.awaddr = a; bus.awvalid = 1'b1; bus.bready = 1'b0;
    bus.wdata = nw; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({bus.rvalid, bus.bvalid, bus.rdata} !== {1'b1, 1'b1, old}) begin
      n_fail++; $display("FAIL same_edge got rv=%b bv=%b rdata=%h want 1/1/%h", bus.rvalid, bus.bvalid, bus.rdata, old);
    end
    bus.rready = 1'b1; bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0; bus.bready = 1'b0;
    model_write(a, nw, 4'hF);
    do_read(a, 0, d, r, lat);
    n_tests++; if (d !== nw) begin n_fail++; $display("FAIL same_edge_after got=%h want=%h", d, nw); end
  endtask

  task automatic test_random();
    logic [31:0] a, d, rd, rnd32; logic [3:0] st; logic [1:0] r; int lat; int unsigned idx;
    for (int i = 0; i < 9; i++) begin
      idx = (i == 8) ? 1023 : i;
      a = BASE + idx * 4; d = $urandom;
      do_write(a, d, 4'hF, r); model_write(a, d, 4'hF);
      n_tests++; if (r !== 2'b00) begin n_fail++; $display("FAIL rand_init idx=%0d bresp=%b want=00", idx, r); end
    end
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        rnd32 = $urandom;
        case ($urandom_range(0, 2))
          0:       a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 15);
          1:       a = BASE - 32'd4;
          default: a = 32'h1000_0000 + (rnd32 & 32'h0FFF_FFFF);
        endcase
      end else begin
        idx = ($urandom_range(0, 8) == 8) ? 1023 : $urandom_range(0, 7);
        a = BASE + idx * 4 + $urandom_range(0, 3);
      end
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; st = 4'($urandom_range(0, 15));
        do_write(a, d, st, r);
        model_write(a, d, st);
        n_tests++;
        if (r !== (in_rng(a) ? 2'b00 : 2'b10)) begin
          n_fail++; $display("FAIL rand_bresp addr=%h got=%b want=%b", a, r, in_rng(a) ? 2'b00 : 2'b10);
        end
      end else begin
        do_read(a, $urandom_range(0, 3), rd, r, lat);
        n_tests++;
        if ({r, rd} !== {(in_rng(a) ? 2'b00 : 2'b10), exp_rdata(a)} || lat !== READ_LAT) begin
          n_fail++; $display("FAIL rand_read addr=%h got resp=%b data=%h lat=%0d want %b/%h/%0d",
                             a, r, rd, lat, in_rng(a) ? 2'b00 : 2'b10, exp_rdata(a), READ_LAT);
        end
      end
    end
  endtask

  initial begin
    bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_basic();
    test_strobe();
    test_w_before_aw();
    test_out_of_range();
    test_rready_stall();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
